mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Owns the single-port instruction/data memory of the multicycle CPU and shares it between two requesters: the fetch path (IR load) and the data path (lw/sw).
- Sequences each access: issues the address, inserts the memory's read wait states, pulses the write strobe, returns read data and acks the requester.
- Removes the explicit MemoryRead/WaitMemoryRead wait sequencing from the main control FSM; that FSM raises a request and waits for ack.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LAT, 2, cycles mem_rdata needs after mem_addr is stable; legal range is 1 to 15.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch read request (level).
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  DATA_W  fetched word.
- ds_req  in  1  data access request (level).
- ds_we  in  1  1 = store, 0 = load.
- ds_addr  in  ADDR_W  data address.
- ds_wdata  in  DATA_W  store data.
- ds_ack  out  1  one-cycle pulse: data access complete.
- ds_rdata  out  DATA_W  loaded word.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wr  out  1  memory write enable (1 = write, 0 = read).
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.
- estado  out  2  current state encoding, for debug.

Behaviour:
- States: IDLE=0, RD=1, WR=2, RESP=3.
- Reset (reset=0, async): state=IDLE, all outputs 0, latency counter 0, last_grant=DATA.
- Reset mid-access aborts it: mem_wr drops to 0 immediately, no ack is issued.
- Sampling: requests are sampled only in IDLE.
- On grant, latch requester id, address (into mem_addr), ds_we and ds_wdata (into mem_wdata). All inputs are ignored until the next IDLE.
- Arbitration, only one request pending: grant it.
- Arbitration, both pending: grant the requester not equal to last_grant, then update last_grant to the winner.
- Consequence: the first tie after reset goes to fetch, and strict alternation prevents starvation.
- Grant to a read (fetch, or data with ds_we=0) goes to RD with counter=0.
- Grant to a store (data with ds_we=1) goes to WR.
- RD: mem_wr=0, mem_addr held; counter increments each cycle.
- RD exit: at the edge where counter==READ_LAT-1, capture mem_rdata into the granted requester's rdata register and go to RESP.
- WR: mem_wr=1 for exactly one cycle, then go to RESP.
- RESP: assert the granted requester's ack for one cycle, then go to IDLE. The other ack stays 0.
- Latency from grant edge to ack high: READ_LAT+1 cycles for reads, 2 cycles for stores.
- if_rdata/ds_rdata: registered; hold their value until the next completed read by the same requester; stores do not change ds_rdata.
- Handshake:
  - A requester holds req and its inputs stable until its ack.
  - req still high in the IDLE cycle after ack counts as a new request.
- Outside WR: mem_wr=0 in IDLE, RD and RESP. mem_addr and mem_wdata keep their last values in IDLE; no glitching to 0.
- Minimum spacing: back-to-back accesses always pass through IDLE, one idle cycle minimum between ack and the next grant.

Decomposition:
- Package mem_seq_pkg:
  - state enum (IDLE, RD, WR, RESP), 2-bit.
  - requester enum (FETCH=0, DATA=1).
  - counter width constant (4 bits).
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], grant-enable.
  - Outputs: one-hot grant.
  - Owns the last_grant flop.
- FSM, latency counter and data capture live in mem_access_sequencer.

Test Plan:
- Fetch read, READ_LAT=2: if_req=1, if_addr=0x10, memory word 0x8C220004.
  - Expect mem_addr=0x10 from the cycle after grant, mem_wr=0 throughout.
  - Expect if_ack high exactly 3 cycles after grant edge, if_rdata=0x8C220004, ds_ack=0.
- Store: ds_req=1, ds_we=1, ds_addr=0x40, ds_wdata=0xDEADBEEF.
  - Expect one cycle of mem_wr=1 with mem_addr=0x40, mem_wdata=0xDEADBEEF.
  - Expect ds_ack on the next cycle; ds_rdata unchanged.
- Simultaneous requests after reset, both held high across two transactions.
  - Fetch granted first, then data (load), with one IDLE cycle between.
  - A third tie grants fetch again.
- Load, then read back the stored word: ds_req=1, ds_we=0, ds_addr=0x40.
  - Expect ds_rdata=0xDEADBEEF with ds_ack; if_rdata unchanged.
- Reset asserted (reset=0) during WR.
  - Expect mem_wr=0 and busy=0 immediately, no ack.
  - After release, the next if_req is serviced normally from IDLE.
- READ_LAT=1 build: fetch read ack 2 cycles after grant edge.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types for the multicycle CPU memory access sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } seqState_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } reqId_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: fetch is req[0], data is req[1].
module rr_arb2
  import mem_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  reqId_e lastGrantQ;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie the requester that did not win last time goes first.
        2'b11:   grant = (lastGrantQ == DATA) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastGrantQ <= DATA;
    end else if (|grant) begin
      lastGrantQ <= grant[1] ? DATA : FETCH;
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Shares the single-port CPU memory between fetch and data requesters, inserting
// read wait states and a one-cycle write strobe, then acking the granted requester.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ds_req,
  input  logic              ds_we,
  input  logic [ADDR_W-1:0] ds_addr,
  input  logic [DATA_W-1:0] ds_wdata,
  output logic              ds_ack,
  output logic [DATA_W-1:0] ds_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        estado
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(READ_LAT - 1);

  seqState_e         stateQ, stateD;
  logic [CNT_W-1:0]  cntQ, cntD;
  reqId_e            grantIdQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memWdataQ;
  logic [DATA_W-1:0] ifRdataQ, dsRdataQ;
  logic [1:0]        grant;
  logic              readDone;

  rr_arb2 uArb (
    .clk   (clk),
    .reset (reset),
    .req   ({ds_req, if_req}),
    .en    (stateQ == IDLE),
    .grant (grant)
  );

  assign readDone = (stateQ == RD) && (cntQ == LastCnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      IDLE: begin
        if (|grant) begin
          stateD = (grant[1] && ds_we) ? WR : RD;
          cntD   = '0;
        end
      end
      RD: begin
        cntD = cntQ + CNT_W'(1);
        if (readDone) stateD = RESP;
      end
      WR:      stateD = RESP;
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    mem_wr = (stateQ == WR);
    if_ack = (stateQ == RESP) && (grantIdQ == FETCH);
    ds_ack = (stateQ == RESP) && (grantIdQ == DATA);
    busy   = (stateQ != IDLE);
    estado = stateQ;
  end

  // Request inputs are latched at grant so the requester's bus is ignored until IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grantIdQ  <= FETCH;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      ifRdataQ  <= '0;
      dsRdataQ  <= '0;
    end else begin
      if ((stateQ == IDLE) && (|grant)) begin
        grantIdQ <= grant[1] ? DATA : FETCH;
        memAddrQ <= grant[1] ? ds_addr : if_addr;
        if (grant[1]) memWdataQ <= ds_wdata;
      end
      if (readDone) begin
        if (grantIdQ == DATA) dsRdataQ <= mem_rdata;
        else                  ifRdataQ <= mem_rdata;
      end
    end
  end

  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign if_rdata  = ifRdataQ;
  assign ds_rdata  = dsRdataQ;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench: stimulus queues expected transactions, a negedge monitor checks them.
module tb_mem_access_sequencer;

  localparam int unsigned READ_LAT = 2;

  typedef struct {
    bit          isData;
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ds_req, ds_we;
  logic [31:0] if_addr, ds_addr, ds_wdata;
  logic        if_ack, ds_ack, mem_wr, busy;
  logic [31:0] if_rdata, ds_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  estado;

  logic        if_req1;
  logic [31:0] if_addr1;
  logic        if_ack1, ds_ack1, mem_wr1, busy1;
  logic [31:0] if_rdata1, ds_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [1:0]  estado1;

  logic [31:0] memArr [0:63];

  exp_t        expQ[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  bit          active = 0;
  bit          haveExp = 0;
  bit          addrBad, wBad;
  int          lat, wrCnt;
  logic [31:0] expIf = '0;
  logic [31:0] expDs = '0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(32), .DATA_W(32), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ds_req(ds_req), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_ack(ds_ack), .ds_rdata(ds_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy), .estado(estado)
  );

  mem_access_sequencer #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .ds_req(1'b0), .ds_we(1'b0), .ds_addr(32'h0), .ds_wdata(32'h0),
    .ds_ack(ds_ack1), .ds_rdata(ds_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1), .mem_rdata(mem_rdata1),
    .busy(busy1), .estado(estado1)
  );

  assign mem_rdata  = memArr[mem_addr[7:2]];
  assign mem_rdata1 = memArr[mem_addr1[7:2]];

  always @(posedge clk) if (mem_wr) memArr[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: tracks each busy window, compares against the queue head at the ack.
  always @(negedge clk) begin
    if (!reset) begin
      active = 0;
      expIf  = '0;
      expDs  = '0;
    end else begin
      if (busy) begin
        if (!active) begin
          active  = 1;
          lat     = 0;
          wrCnt   = 0;
          addrBad = 0;
          wBad    = 0;
          haveExp = (expQ.size() > 0);
          if (haveExp) cur = expQ[0];
        end
        lat++;
        if (mem_wr) begin
          wrCnt++;
          if (haveExp && mem_wdata !== cur.wdata) wBad = 1;
        end
        if (haveExp && mem_addr !== cur.addr) addrBad = 1;
      end
      if (if_ack || ds_ack) begin
        if (!active || !haveExp) begin
          check("unexpected_ack", {30'b0, ds_ack, if_ack}, 32'h0);
        end else begin
          void'(expQ.pop_front());
          check("ack_id", {31'b0, ds_ack}, {31'b0, cur.isData});
          check("single_ack", {31'b0, if_ack & ds_ack}, 32'h0);
          check("ack_latency", lat, cur.lat);
          check("wr_cycles", wrCnt, {31'b0, cur.isWrite});
          check("addr_held", {31'b0, addrBad}, 32'h0);
          check("wdata", {31'b0, wBad}, 32'h0);
          if (!cur.isWrite) begin
            if (cur.isData) expDs = cur.rdata;
            else            expIf = cur.rdata;
          end
          check("if_rdata", if_rdata, expIf);
          check("ds_rdata", ds_rdata, expDs);
        end
        active = 0;
      end
    end
  end

  task automatic waitAck(input bit isData);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (isData ? ds_ack : if_ack) seen = 1;
    end
    if (!seen) check("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic pushExp(input bit isData, input bit isWrite, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int lt);
    exp_t e;
    e.isData = isData; e.isWrite = isWrite; e.addr = addr;
    e.wdata = wdata; e.rdata = rdata; e.lat = lt;
    expQ.push_back(e);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int cyc;
    for (int i = 0; i < 64; i++) memArr[i] = '0;
    memArr[32'h10 >> 2] = 32'h8C220004;
    memArr[32'h14 >> 2] = 32'h11112222;
    memArr[32'h20 >> 2] = 32'hCAFEF00D;
    reset = 1'b0;
    if_req = 0; if_addr = '0; ds_req = 0; ds_we = 0; ds_addr = '0; ds_wdata = '0;
    if_req1 = 0; if_addr1 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_estado", {30'b0, estado}, 32'h0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_acks", {30'b0, ds_ack, if_ack}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rdata", if_rdata | ds_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Fetch read.
    if_addr = 32'h10; if_req = 1;
    pushExp(0, 0, 32'h10, 32'h0, 32'h8C220004, READ_LAT + 1);
    waitAck(0); if_req = 0;
    @(negedge clk);

    // Store.
    ds_we = 1; ds_addr = 32'h40; ds_wdata = 32'hDEADBEEF; ds_req = 1;
    pushExp(1, 1, 32'h40, 32'hDEADBEEF, 32'h0, 2);
    waitAck(1); ds_req = 0;
    @(negedge clk);

    // Load back the stored word.
    ds_we = 0; ds_addr = 32'h40; ds_req = 1;
    pushExp(1, 0, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, READ_LAT + 1);
    waitAck(1); ds_req = 0;
    @(negedge clk);

    // Ties after reset: fetch, then data, then fetch again.
    pulseReset();
    if_addr = 32'h14; ds_we = 0; ds_addr = 32'h40; ds_wdata = 32'h0;
    pushExp(0, 0, 32'h14, 32'h0, 32'h11112222, READ_LAT + 1);
    pushExp(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, READ_LAT + 1);
    if_req = 1; ds_req = 1;
    waitAck(0); if_req = 0;
    waitAck(1); ds_req = 0;
    @(negedge clk);
    if_addr = 32'h10;
    pushExp(0, 0, 32'h10, 32'h0, 32'h8C220004, READ_LAT + 1);
    pushExp(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, READ_LAT + 1);
    if_req = 1; ds_req = 1;
    waitAck(0); if_req = 0;
    waitAck(1); ds_req = 0;
    @(negedge clk);

    // Reset while in WR aborts the store.
    ds_we = 1; ds_addr = 32'h44; ds_wdata = 32'h12345678; ds_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_wr) seen = 1;
    end
    check("saw_mem_wr", {31'b0, seen}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    ds_req = 0; ds_we = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", memArr[32'h44 >> 2], 32'h0);

    if_addr = 32'h20; if_req = 1;
    pushExp(0, 0, 32'h20, 32'h0, 32'hCAFEF00D, READ_LAT + 1);
    waitAck(0); if_req = 0;
    repeat (2) @(negedge clk);
    check("queue_drained", expQ.size(), 32'h0);

    // READ_LAT=1 instance: ack two cycles after grant.
    if_addr1 = 32'h10; if_req1 = 1;
    seen = 0; cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy1) cyc++;
      if (if_ack1) begin
        seen = 1;
        check("lat1_ds_ack", {31'b0, ds_ack1}, 32'h0);
        check("lat1_rdata", if_rdata1, 32'h8C220004);
      end
    end
    if_req1 = 0;
    check("lat1_seen", {31'b0, seen}, 32'h1);
    check("lat1_latency", cyc, 32'd2);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
